writeback_select_stage: RTL

Parametrised, registered write-back stage for the CPU datapath. It selects one of `NUM_SRC` result sources (ALU result, memory read data, and further sources such as PC+4 or immediates) and delivers the chosen value, destination register and write strobe to the register file one cycle later. Loads stall in this stage until the data cache/memory drops `BUSYWAIT`. It generalises the 8-bit 2:1 ALU/memory write mux to arbitrary width and source count, with pipelining, miss stalls and select-error detection.

---
 rtl/writeback_select_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/writeback_select_stage.sv
// writeback_select_stage: registered write-back mux with load-miss stall.
// Picks one of NUM_SRC sources and presents data/reg/strobe one cycle later.
// Memory-sourced writes wait in WAIT_MEM while BUSYWAIT is high.
module writeback_select_stage #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_SRC        = 2,
    parameter int SEL_WIDTH      = 1,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int MEM_SRC        = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] SRC_DATA,
    input  logic [SEL_WIDTH-1:0]          WRITEMUX_SEL,
    input  logic                          WRITEENABLE,
    input  logic [REG_ADDR_WIDTH-1:0]     WRITEREG,
    input  logic                          BUSYWAIT,
    output logic                          STALL,
    output logic [DATA_WIDTH-1:0]         WB_DATA,
    output logic [REG_ADDR_WIDTH-1:0]     WB_REG,
    output logic                          WB_EN,
    output logic                          SEL_ERR
);

    typedef enum logic {PASS = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_reg_q, wb_reg_d;
    logic [REG_ADDR_WIDTH-1:0] pend_reg_q, pend_reg_d;
    logic                      wb_en_q, wb_en_d;
    logic                      sel_err_q, sel_err_d;

    logic [DATA_WIDTH-1:0]     sel_data;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      sel_ok;
    logic                      sel_mem;
    logic                      stall;

    // Source decode: selected data, range check and memory-source match
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(WRITEMUX_SEL) == i) sel_data = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        end
        mem_data = SRC_DATA[MEM_SRC*DATA_WIDTH +: DATA_WIDTH];
        sel_ok   = (int'(WRITEMUX_SEL) < NUM_SRC);
        sel_mem  = (int'(WRITEMUX_SEL) == MEM_SRC);
    end

    // Next-state and output logic; write strobe defaults low so it pulses
    always_comb begin
        state_d    = state_q;
        wb_data_d  = wb_data_q;
        wb_reg_d   = wb_reg_q;
        pend_reg_d = pend_reg_q;
        wb_en_d    = 1'b0;
        sel_err_d  = sel_err_q;
        stall      = 1'b0;
        unique case (state_q)
            PASS: begin
                if (WRITEENABLE) begin
                    if (!sel_ok) begin
                        // Out-of-range select: drop the write, flag it stickily
                        sel_err_d = 1'b1;
                    end else if (sel_mem && BUSYWAIT) begin
                        // Load miss: hold the destination until memory is ready
                        stall      = 1'b1;
                        pend_reg_d = WRITEREG;
                        state_d    = WAIT_MEM;
                    end else begin
                        wb_data_d = sel_data;
                        wb_reg_d  = WRITEREG;
                        wb_en_d   = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Upstream request is frozen; only BUSYWAIT matters here
                stall = 1'b1;
                if (!BUSYWAIT) begin
                    wb_data_d = mem_data;
                    wb_reg_d  = pend_reg_q;
                    wb_en_d   = 1'b1;
                    state_d   = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    // State and output registers; reset wins over everything, abandoning a pending load
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= PASS;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            pend_reg_q <= '0;
            wb_en_q    <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_data_q  <= wb_data_d;
            wb_reg_q   <= wb_reg_d;
            pend_reg_q <= pend_reg_d;
            wb_en_q    <= wb_en_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign STALL   = stall;
    assign WB_DATA = wb_data_q;
    assign WB_REG  = wb_reg_q;
    assign WB_EN   = wb_en_q;
    assign SEL_ERR = sel_err_q;

endmodule
